// File: rtl/mips_wb_pkg.sv
// Shared constants and types for the MINI-MIPS writeback stage.
package mips_wb_pkg;
   localparam int               REG_AW      = 5;
   localparam logic [1:0]        REGDST_LINK = 2'b10;
   localparam logic [REG_AW-1:0] REG_ZERO    = 5'd0;

   // Which source owns the register-file write port in a given cycle
   typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LINK, WB_LOAD} wb_src_e;
endpackage

// File: rtl/wb_load_tag_fifo.sv
// In-order queue of destination registers for loads still waiting on memory.
// Also answers two hazard queries in parallel against the live entries.
module wb_load_tag_fifo
   import mips_wb_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [REG_AW-1:0] push_tag,
   input  logic              pop,
   output logic [REG_AW-1:0] head_tag,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   input  logic [REG_AW-1:0] query_rs,
   input  logic [REG_AW-1:0] query_rt,
   output logic              hit_rs,
   output logic              hit_rt
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][REG_AW-1:0] tags;
   logic [AW-1:0]                wr_ptr, rd_ptr;
   logic [DEPTH-1:0]             live, m_rs, m_rt;

   assign head_tag = tags[rd_ptr];
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);

   // Tag storage carries no reset; only entries covered by count are ever read
   always_ff @(posedge clk) begin
      if (push) tags[wr_ptr] <= push_tag;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // An entry is live when its distance from the head is below count
   for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign live[g] = ({1'b0, AW'(g) - rd_ptr} < count);
      assign m_rs[g] = live[g] && (tags[g] == query_rs);
      assign m_rt[g] = live[g] && (tags[g] == query_rt);
   end

   assign hit_rs = (|m_rs) && (query_rs != REG_ZERO);
   assign hit_rt = (|m_rt) && (query_rt != REG_ZERO);
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU/link results
// and returning load data; load returns always win since memory cannot stall.
module wb_port_arbiter
   import mips_wb_pkg::*;
#(
   parameter int LOAD_DEPTH = 2,
   parameter int DW         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              ex_memToReg,
   input  logic [1:0]        ex_regDst,
   input  logic [REG_AW-1:0] ex_waddr,
   input  logic [DW-1:0]     ex_alu_result,
   input  logic [DW-1:0]     ex_pc_plus_four,
   input  logic              mem_rvalid,
   input  logic [DW-1:0]     mem_rdata,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DW-1:0]     rf_wdata,
   input  logic [REG_AW-1:0] query_rs,
   input  logic [REG_AW-1:0] query_rt,
   output logic              pend_hit_rs,
   output logic              pend_hit_rt,
   output logic              load_pending,
   output logic              err_underflow
);
   localparam int AW = $clog2(LOAD_DEPTH);

   logic              q_full, q_empty, q_push, q_pop;
   logic [REG_AW-1:0] q_head;
   logic [AW:0]       q_count;
   wb_src_e           src;

   // A load only needs a free slot; a non-load needs the port itself
   assign ex_ready = ex_memToReg ? !q_full : !mem_rvalid;

   assign q_pop        = mem_rvalid && !q_empty;
   assign q_push       = ex_valid && ex_ready && ex_memToReg;
   assign load_pending = !q_empty;

   // Pick the port owner; returns with an empty queue are dropped
   always_comb begin
      src = WB_NONE;
      if (q_pop)
         src = WB_LOAD;
      else if (ex_valid && ex_ready && !ex_memToReg)
         src = (ex_regDst == REGDST_LINK) ? WB_LINK : WB_ALU;
   end

   wb_load_tag_fifo #(.DEPTH(LOAD_DEPTH)) u_tags (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (q_push),
      .push_tag (ex_waddr),
      .pop      (q_pop),
      .head_tag (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty),
      .query_rs (query_rs),
      .query_rt (query_rt),
      .hit_rs   (pend_hit_rs),
      .hit_rt   (pend_hit_rt)
   );

   // Registered write stage; address/data hold on idle cycles, $0 never writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we         <= 1'b0;
         rf_waddr      <= '0;
         rf_wdata      <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (mem_rvalid && q_empty) err_underflow <= 1'b1;
         case (src)
            WB_LOAD: begin
               rf_we    <= (q_head != REG_ZERO);
               rf_waddr <= q_head;
               rf_wdata <= mem_rdata;
            end
            WB_LINK: begin
               rf_we    <= (ex_waddr != REG_ZERO);
               rf_waddr <= ex_waddr;
               rf_wdata <= ex_pc_plus_four;
            end
            WB_ALU: begin
               rf_we    <= (ex_waddr != REG_ZERO);
               rf_waddr <= ex_waddr;
               rf_wdata <= ex_alu_result;
            end
            default: rf_we <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for the writeback port arbiter with hand-computed expectations.
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready, ex_memToReg;
   logic [1:0]  ex_regDst;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_alu_result, ex_pc_plus_four;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  query_rs, query_rt;
   logic        pend_hit_rs, pend_hit_rt, load_pending, err_underflow;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.LOAD_DEPTH(2), .DW(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_memToReg     (ex_memToReg),
      .ex_regDst       (ex_regDst),
      .ex_waddr        (ex_waddr),
      .ex_alu_result   (ex_alu_result),
      .ex_pc_plus_four (ex_pc_plus_four),
      .mem_rvalid      (mem_rvalid),
      .mem_rdata       (mem_rdata),
      .rf_we           (rf_we),
      .rf_waddr        (rf_waddr),
      .rf_wdata        (rf_wdata),
      .query_rs        (query_rs),
      .query_rt        (query_rt),
      .pend_hit_rs     (pend_hit_rs),
      .pend_hit_rt     (pend_hit_rt),
      .load_pending    (load_pending),
      .err_underflow   (err_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and land 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic ld, input logic [1:0] rd,
                           input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc4);
      ex_valid = v; ex_memToReg = ld; ex_regDst = rd;
      ex_waddr = wa; ex_alu_result = alu; ex_pc_plus_four = pc4;
   endtask

   task automatic drive_mem(input logic v, input logic [31:0] d);
      mem_rvalid = v; mem_rdata = d;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      drive_mem(0, 32'h0);
      query_rs = 5'd0; query_rt = 5'd0;
      tick(); tick();
      chk("rst_we", 32'(rf_we), 32'h0);
      chk("rst_waddr", 32'(rf_waddr), 32'h0);
      chk("rst_wdata", rf_wdata, 32'h0);
      chk("rst_err", 32'(err_underflow), 32'h0);
      chk("rst_pending", 32'(load_pending), 32'h0);
      rst_n = 1'b1;
      tick();

      // ALU result, then an idle cycle holding address/data
      drive_ex(1, 0, 2'b00, 5'd8, 32'h1234, 32'h0000_0100);
      #1 chk("alu_ready", 32'(ex_ready), 32'h1);
      tick();
      chk("alu_we", 32'(rf_we), 32'h1);
      chk("alu_waddr", 32'(rf_waddr), 32'd8);
      chk("alu_wdata", rf_wdata, 32'h1234);
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      tick();
      chk("idle_we", 32'(rf_we), 32'h0);
      chk("idle_waddr", 32'(rf_waddr), 32'd8);
      chk("idle_wdata", rf_wdata, 32'h1234);

      // JAL to $31, then to $0
      drive_ex(1, 0, 2'b10, 5'd31, 32'hFFFF_FFFF, 32'h0040_0008);
      tick();
      chk("jal_we", 32'(rf_we), 32'h1);
      chk("jal_waddr", 32'(rf_waddr), 32'd31);
      chk("jal_wdata", rf_wdata, 32'h0040_0008);
      drive_ex(1, 0, 2'b10, 5'd0, 32'hFFFF_FFFF, 32'h0040_000C);
      tick();
      chk("jal0_we", 32'(rf_we), 32'h0);
      chk("jal0_waddr", 32'(rf_waddr), 32'd0);
      chk("jal0_wdata", rf_wdata, 32'h0040_000C);

      // Load to $9, data returns three cycles after issue
      drive_ex(1, 1, 2'b00, 5'd9, 32'h0, 32'h0);
      query_rs = 5'd9; query_rt = 5'd10;
      #1 chk("ld_ready", 32'(ex_ready), 32'h1);
      chk("ld_hit_pre", 32'(pend_hit_rs), 32'h0);
      tick();
      chk("ld_we", 32'(rf_we), 32'h0);
      chk("ld_pending", 32'(load_pending), 32'h1);
      chk("ld_hit_rs1", 32'(pend_hit_rs), 32'h1);
      chk("ld_hit_rt", 32'(pend_hit_rt), 32'h0);
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      tick();
      chk("ld_hit_rs2", 32'(pend_hit_rs), 32'h1);
      tick();
      drive_mem(1, 32'hDEAD_BEEF);
      #1 chk("ld_hit_rs3", 32'(pend_hit_rs), 32'h1);
      tick();
      chk("ret_we", 32'(rf_we), 32'h1);
      chk("ret_waddr", 32'(rf_waddr), 32'd9);
      chk("ret_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("ret_hit_rs", 32'(pend_hit_rs), 32'h0);
      chk("ret_pending", 32'(load_pending), 32'h0);
      drive_mem(0, 32'h0);

      // Fill the queue, then a return while full still blocks the third load
      drive_ex(1, 1, 2'b00, 5'd3, 32'h0, 32'h0);
      tick();
      drive_ex(1, 1, 2'b00, 5'd4, 32'h0, 32'h0);
      #1 chk("fill_ready", 32'(ex_ready), 32'h1);
      tick();
      drive_ex(1, 1, 2'b00, 5'd6, 32'h0, 32'h0);
      #1 chk("full_ready", 32'(ex_ready), 32'h0);
      drive_mem(1, 32'h1111_1111);
      #1 chk("full_ret_ready", 32'(ex_ready), 32'h0);
      tick();
      chk("full_ret_waddr", 32'(rf_waddr), 32'd3);
      chk("full_ret_wdata", rf_wdata, 32'h1111_1111);
      drive_mem(0, 32'h0);
      #1 chk("third_ready", 32'(ex_ready), 32'h1);
      tick();
      chk("third_we", 32'(rf_we), 32'h0);
      query_rs = 5'd4; query_rt = 5'd6;
      #1 chk("q_hit_rs4", 32'(pend_hit_rs), 32'h1);
      chk("q_hit_rt6", 32'(pend_hit_rt), 32'h1);
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      drive_mem(1, 32'h2222_2222);
      tick();
      chk("ret4_we", 32'(rf_we), 32'h1);
      chk("ret4_waddr", 32'(rf_waddr), 32'd4);
      chk("ret4_wdata", rf_wdata, 32'h2222_2222);

      // Return and load accept together at count 1
      drive_mem(1, 32'h3333_3333);
      drive_ex(1, 1, 2'b00, 5'd7, 32'h0, 32'h0);
      #1 chk("pp_ready", 32'(ex_ready), 32'h1);
      tick();
      chk("pp_waddr", 32'(rf_waddr), 32'd6);
      chk("pp_wdata", rf_wdata, 32'h3333_3333);
      chk("pp_pending", 32'(load_pending), 32'h1);
      query_rs = 5'd7; query_rt = 5'd6;
      #1 chk("pp_hit_rs7", 32'(pend_hit_rs), 32'h1);
      chk("pp_hit_rt6", 32'(pend_hit_rt), 32'h0);

      // Return coincident with an ALU op: load first, ALU next cycle
      drive_mem(1, 32'h4444_4444);
      drive_ex(1, 0, 2'b00, 5'd5, 32'h5555, 32'h0);
      #1 chk("col_ready", 32'(ex_ready), 32'h0);
      tick();
      chk("col_ld_we", 32'(rf_we), 32'h1);
      chk("col_ld_waddr", 32'(rf_waddr), 32'd7);
      chk("col_ld_wdata", rf_wdata, 32'h4444_4444);
      drive_mem(0, 32'h0);
      #1 chk("col_ready2", 32'(ex_ready), 32'h1);
      tick();
      chk("col_alu_waddr", 32'(rf_waddr), 32'd5);
      chk("col_alu_wdata", rf_wdata, 32'h5555);
      chk("col_pending", 32'(load_pending), 32'h0);

      // Load to $0 still queued and consumed, but never writes
      drive_ex(1, 1, 2'b00, 5'd0, 32'h0, 32'h0);
      query_rs = 5'd0;
      tick();
      chk("z_pending", 32'(load_pending), 32'h1);
      chk("z_hit", 32'(pend_hit_rs), 32'h0);
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      drive_mem(1, 32'h6666);
      tick();
      chk("z_we", 32'(rf_we), 32'h0);
      chk("z_wdata", rf_wdata, 32'h6666);
      chk("z_err", 32'(err_underflow), 32'h0);
      chk("z_pending2", 32'(load_pending), 32'h0);

      // Underflow: ignored data, sticky error
      drive_mem(1, 32'h7777);
      tick();
      chk("uf_we", 32'(rf_we), 32'h0);
      chk("uf_err", 32'(err_underflow), 32'h1);
      chk("uf_wdata", rf_wdata, 32'h6666);
      drive_mem(0, 32'h0);
      tick(); tick();
      chk("uf_sticky", 32'(err_underflow), 32'h1);

      // Reset mid-load clears everything; a later return is an underflow
      drive_ex(1, 1, 2'b00, 5'd12, 32'h0, 32'h0);
      tick();
      chk("mr_pending", 32'(load_pending), 32'h1);
      drive_ex(0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
      rst_n = 1'b0;
      #1 chk("mr_pending0", 32'(load_pending), 32'h0);
      chk("mr_err", 32'(err_underflow), 32'h0);
      chk("mr_we", 32'(rf_we), 32'h0);
      chk("mr_waddr", 32'(rf_waddr), 32'h0);
      chk("mr_wdata", rf_wdata, 32'h0);
      #2 rst_n = 1'b1;
      drive_mem(1, 32'h8888);
      tick();
      chk("mr_uf_err", 32'(err_underflow), 32'h1);
      chk("mr_uf_we", 32'(rf_we), 32'h0);
      drive_mem(0, 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
